// File: rtl/anaio_mux_pkg.sv
// Shared state encoding, default parameters and counter width for the ANAIO pad mux sequencer.
package anaio_mux_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BREAK  = 2'd1,
        ST_SETTLE = 2'd2
    } state_e;

    localparam int NUM_SRC_DEF    = 8;
    localparam int DEAD_CYC_DEF   = 4;
    localparam int SETTLE_CYC_DEF = 16;
    localparam int CNT_W          = 8;

endpackage

// File: rtl/anaio_mux_cnt.sv
// Loadable down-counter with zero flag, shared by the dead-time and settle phases.
module anaio_mux_cnt
    import anaio_mux_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Load wins over decrement; the count parks at zero rather than wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/anaio_mux_seq.sv
// Break-before-make sequencer routing one of NUM_SRC analog sources to the ANAIO pad.
// Optional `ANAIO_MUX_ABORT_EN adds an abort input that gates the switches off immediately.
module anaio_mux_seq
    import anaio_mux_pkg::*;
#(
    parameter int NUM_SRC    = NUM_SRC_DEF,
    parameter int DEAD_CYC   = DEAD_CYC_DEF,
    parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
`ifdef ANAIO_MUX_ABORT_EN
    input  logic                       abort,
`endif
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [$clog2(NUM_SRC)-1:0] req_sel,
    input  logic                       req_off,
    output logic [NUM_SRC-1:0]         sw_en,
    output logic [$clog2(NUM_SRC)-1:0] cur_sel,
    output logic                       connected,
    output logic                       done,
    output logic                       err
);

    localparam int               SEL_W       = $clog2(NUM_SRC);
    localparam logic [SEL_W:0]   SRC_LIMIT   = (SEL_W+1)'(NUM_SRC);
    localparam logic [CNT_W-1:0] DEAD_LOAD   = CNT_W'(DEAD_CYC - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   tgt_q, tgt_d;
    logic               off_q, off_d;
    logic [NUM_SRC-1:0] sw_en_q, sw_en_d;
    logic [SEL_W-1:0]   cur_sel_q, cur_sel_d;
    logic               connected_q, connected_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic               cnt_load;
    logic [CNT_W-1:0]   cnt_val;
    logic               cnt_dec;
    logic               cnt_zero;
    logic               accept;
    logic               abort_w;

`ifdef ANAIO_MUX_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    // Ready is masked by reset so nothing is accepted while the block is held in reset.
    assign req_ready = rst_n && (state_q == ST_IDLE) && !abort_w;
    assign accept    = req_valid && req_ready;

    anaio_mux_cnt u_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (cnt_load),
        .val_i  (cnt_val),
        .dec_i  (cnt_dec),
        .zero_o (cnt_zero)
    );

    always_comb begin
        state_d     = state_q;
        tgt_d       = tgt_q;
        off_d       = off_q;
        sw_en_d     = sw_en_q;
        cur_sel_d   = cur_sel_q;
        connected_d = connected_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        cnt_load    = 1'b0;
        cnt_val     = DEAD_LOAD;
        cnt_dec     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (req_off) begin
                        state_d     = ST_BREAK;
                        off_d       = 1'b1;
                        sw_en_d     = '0;
                        connected_d = 1'b0;
                        cnt_load    = 1'b1;
                    end else if ({1'b0, req_sel} >= SRC_LIMIT) begin
                        err_d = 1'b1;
                    end else if (connected_q && (req_sel == cur_sel_q)) begin
                        // Already routed and settled: acknowledge without touching the switch.
                        done_d = 1'b1;
                    end else begin
                        state_d     = ST_BREAK;
                        off_d       = 1'b0;
                        tgt_d       = req_sel;
                        sw_en_d     = '0;
                        connected_d = 1'b0;
                        cnt_load    = 1'b1;
                    end
                end
            end
            ST_BREAK: begin
                if (cnt_zero) begin
                    if (off_q) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d  = ST_SETTLE;
                        sw_en_d  = {{(NUM_SRC-1){1'b0}}, 1'b1} << tgt_q;
                        cnt_load = 1'b1;
                        cnt_val  = SETTLE_LOAD;
                    end
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (cnt_zero) begin
                    state_d     = ST_IDLE;
                    done_d      = 1'b1;
                    connected_d = 1'b1;
                    cur_sel_d   = tgt_q;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort overrides everything; err flags only an interrupted request.
        if (abort_w) begin
            state_d     = ST_IDLE;
            sw_en_d     = '0;
            connected_d = 1'b0;
            done_d      = 1'b0;
            err_d       = (state_q != ST_IDLE);
            cnt_load    = 1'b0;
            cnt_dec     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            tgt_q       <= '0;
            off_q       <= 1'b0;
            sw_en_q     <= '0;
            cur_sel_q   <= '0;
            connected_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            tgt_q       <= tgt_d;
            off_q       <= off_d;
            sw_en_q     <= sw_en_d;
            cur_sel_q   <= cur_sel_d;
            connected_q <= connected_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign sw_en     = sw_en_q & ~{NUM_SRC{abort_w}};
    assign connected = connected_q && !abort_w;
    assign cur_sel   = cur_sel_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_anaio_mux_seq.sv
// Bench for anaio_mux_seq; NUM_SRC=6 so that a 3-bit select can address non-existent sources.
module tb_anaio_mux_seq;

    localparam int NSRC   = 6;
    localparam int DEAD   = 4;
    localparam int SETTLE = 16;
    localparam int SW     = 3;

    logic            clk       = 1'b0;
    logic            rst_n     = 1'b1;
    logic            req_valid = 1'b0;
    logic            req_off   = 1'b0;
    logic [SW-1:0]   req_sel   = '0;
    logic            req_ready;
    logic [NSRC-1:0] sw_en;
    logic [SW-1:0]   cur_sel;
    logic            connected;
    logic            done;
    logic            err;
`ifdef ANAIO_MUX_ABORT_EN
    logic            abort     = 1'b0;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [NSRC-1:0] sw;
        bit              conn;
        bit              dn;
        bit              er;
        bit              rdy;
        int              sel;
    } exp_t;

    exp_t            trace[$];
    bit              m_conn;
    int              m_sel;
    logic [NSRC-1:0] m_sw;

    always #5 clk = ~clk;

    anaio_mux_seq #(
        .NUM_SRC    (NSRC),
        .DEAD_CYC   (DEAD),
        .SETTLE_CYC (SETTLE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef ANAIO_MUX_ABORT_EN
        .abort     (abort),
`endif
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_sel   (req_sel),
        .req_off   (req_off),
        .sw_en     (sw_en),
        .cur_sel   (cur_sel),
        .connected (connected),
        .done      (done),
        .err       (err)
    );

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NSRC-1:0] onehot(input int s);
        logic [NSRC-1:0] v;
        v = 1;
        return v << s;
    endfunction

    // Expected per-cycle outputs of one accepted request, derived from the routing rules.
    task automatic build(input int sel, input bit off);
        exp_t e;
        trace.delete();
        if (!off && sel >= NSRC) begin
            e = '{m_sw, m_conn, 1'b0, 1'b1, 1'b1, m_sel};
            trace.push_back(e);
        end else if (!off && m_conn && sel == m_sel) begin
            e = '{m_sw, 1'b1, 1'b1, 1'b0, 1'b1, m_sel};
            trace.push_back(e);
        end else begin
            for (int i = 0; i < DEAD; i++) begin
                e = '{'0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
                trace.push_back(e);
            end
            if (!off) begin
                for (int i = 0; i < SETTLE; i++) begin
                    e = '{onehot(sel), 1'b0, 1'b0, 1'b0, 1'b0, 0};
                    trace.push_back(e);
                end
                m_sel = sel;
            end
            m_sw   = off ? '0 : onehot(sel);
            m_conn = !off;
            e = '{m_sw, m_conn, 1'b1, 1'b0, 1'b1, m_sel};
            trace.push_back(e);
        end
    endtask

    task automatic present(input int sel, input bit off);
        req_valid = 1'b1;
        req_sel   = SW'(sel);
        req_off   = off;
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL accept sel=%0d: req_ready got %b want 1", sel, req_ready);
        end
        step();
        req_valid = 1'b0;
        build(sel, off);
    endtask

    // Walks the expected trace cycle by cycle; optionally holds the next request pending.
    task automatic follow(input string tag, input bit pend, input int psel, input bit poff,
                          output int zeros);
        zeros = 0;
        if (pend) begin
            req_valid = 1'b1;
            req_sel   = SW'(psel);
            req_off   = poff;
        end else begin
            req_sel = SW'($urandom);
            req_off = 1'($urandom);
        end
        foreach (trace[i]) begin
            if (sw_en == '0) zeros++;
            n_cmp += 6;
            if (sw_en !== trace[i].sw) begin
                n_bad++;
                $display("[TB] FAIL %s c%0d sw_en: got %h want %h", tag, i + 1, sw_en, trace[i].sw);
            end
            if (connected !== trace[i].conn) begin
                n_bad++;
                $display("[TB] FAIL %s c%0d connected: got %b want %b", tag, i + 1, connected, trace[i].conn);
            end
            if (done !== trace[i].dn) begin
                n_bad++;
                $display("[TB] FAIL %s c%0d done: got %b want %b", tag, i + 1, done, trace[i].dn);
            end
            if (err !== trace[i].er) begin
                n_bad++;
                $display("[TB] FAIL %s c%0d err: got %b want %b", tag, i + 1, err, trace[i].er);
            end
            if (req_ready !== trace[i].rdy) begin
                n_bad++;
                $display("[TB] FAIL %s c%0d req_ready: got %b want %b", tag, i + 1, req_ready, trace[i].rdy);
            end
            if ($countones(sw_en) > 1) begin
                n_bad++;
                $display("[TB] FAIL %s c%0d onehot: got %h want at most one bit", tag, i + 1, sw_en);
            end
            if (trace[i].conn) begin
                n_cmp++;
                if (cur_sel !== SW'(trace[i].sel)) begin
                    n_bad++;
                    $display("[TB] FAIL %s c%0d cur_sel: got %0d want %0d", tag, i + 1, cur_sel, trace[i].sel);
                end
            end
            step();
        end
        req_valid = 1'b0;
        if (!pend) begin
            n_cmp += 4;
            if (done !== 1'b0 || err !== 1'b0) begin
                n_bad++;
                $display("[TB] FAIL %s after pulses: got done=%b err=%b want 0/0", tag, done, err);
            end
            if (req_ready !== 1'b1) begin
                n_bad++;
                $display("[TB] FAIL %s after ready: got %b want 1", tag, req_ready);
            end
            if (sw_en !== m_sw) begin
                n_bad++;
                $display("[TB] FAIL %s after sw_en: got %h want %h", tag, sw_en, m_sw);
            end
            if (connected !== m_conn) begin
                n_bad++;
                $display("[TB] FAIL %s after connected: got %b want %b", tag, connected, m_conn);
            end
        end
    endtask

    task automatic test_reset();
        int z;
        #1 rst_n = 1'b0;
        #2;
        n_cmp += 2;
        if (req_ready !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL reset ready: got %b want 0", req_ready);
        end
        if (sw_en !== '0 || connected !== 1'b0 || done !== 1'b0 || err !== 1'b0 || cur_sel !== '0) begin
            n_bad++;
            $display("[TB] FAIL reset outputs: got sw=%h conn=%b done=%b err=%b sel=%0d want all 0",
                     sw_en, connected, done, err, cur_sel);
        end
        step();
        step();
        rst_n = 1'b1;
        step();
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL reset release ready: got %b want 1", req_ready);
        end
        m_conn = 1'b0;
        m_sel  = 0;
        m_sw   = '0;
        z      = 0;
    endtask

    task automatic test_connect();
        int z;
        present(3, 1'b0);
        follow("connect3", 1'b0, 0, 1'b0, z);
    endtask

    task automatic test_switch();
        int z;
        present(5, 1'b0);
        follow("switch5", 1'b0, 0, 1'b0, z);
        n_cmp++;
        if (z != DEAD) begin
            n_bad++;
            $display("[TB] FAIL switch dead time: got %0d zero cycles want %0d", z, DEAD);
        end
    endtask

    task automatic test_repeat();
        int z;
        present(3, 1'b0);
        follow("repeat_setup", 1'b0, 0, 1'b0, z);
        present(3, 1'b0);
        follow("repeat3", 1'b0, 0, 1'b0, z);
        n_cmp++;
        if (z != 0) begin
            n_bad++;
            $display("[TB] FAIL repeat toggled: got %0d zero cycles want 0", z);
        end
    endtask

    task automatic test_invalid();
        int z;
        present(7, 1'b0);
        follow("invalid7", 1'b0, 0, 1'b0, z);
        present(6, 1'b0);
        follow("invalid6", 1'b0, 0, 1'b0, z);
    endtask

    task automatic test_off();
        int z;
        present(7, 1'b1);
        follow("off", 1'b0, 0, 1'b0, z);
        present(2, 1'b1);
        follow("off_again", 1'b0, 0, 1'b0, z);
    endtask

    task automatic test_back_to_back();
        int z;
        present(1, 1'b0);
        follow("b2b_first", 1'b1, 4, 1'b0, z);
        build(4, 1'b0);
        follow("b2b_held", 1'b1, 0, 1'b1, z);
        build(0, 1'b1);
        follow("b2b_off", 1'b0, 0, 1'b0, z);
    endtask

    task automatic test_reset_mid();
        present(3, 1'b0);
        repeat (9) step();
        rst_n = 1'b0;
        #1;
        n_cmp += 2;
        if (sw_en !== '0 || connected !== 1'b0 || done !== 1'b0 || err !== 1'b0 || cur_sel !== '0) begin
            n_bad++;
            $display("[TB] FAIL midreset outputs: got sw=%h conn=%b done=%b err=%b sel=%0d want all 0",
                     sw_en, connected, done, err, cur_sel);
        end
        if (req_ready !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL midreset ready: got %b want 0", req_ready);
        end
        step();
        step();
        rst_n = 1'b1;
        step();
        n_cmp++;
        if (req_ready !== 1'b1 || sw_en !== '0) begin
            n_bad++;
            $display("[TB] FAIL midreset release: got ready=%b sw=%h want 1/0", req_ready, sw_en);
        end
        m_conn = 1'b0;
        m_sel  = 0;
        m_sw   = '0;
    endtask

`ifdef ANAIO_MUX_ABORT_EN
    task automatic test_abort();
        present(2, 1'b0);
        repeat (6) step();
        abort = 1'b1;
        #1;
        n_cmp++;
        if (sw_en !== '0 || connected !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL abort gate: got sw=%h conn=%b want 0/0", sw_en, connected);
        end
        step();
        abort = 1'b0;
        #1;
        n_cmp++;
        if (err !== 1'b1 || req_ready !== 1'b1 || sw_en !== '0) begin
            n_bad++;
            $display("[TB] FAIL abort err: got err=%b ready=%b sw=%h want 1/1/0", err, req_ready, sw_en);
        end
        step();
        n_cmp++;
        if (err !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL abort err pulse: got %b want 0", err);
        end
        m_conn = 1'b0;
        m_sw   = '0;
    endtask
`endif

    task automatic test_random();
        int z;
        int sel;
        bit off;
        for (int k = 0; k < 14; k++) begin
            off = ($urandom_range(0, 4) == 0);
            sel = ($urandom_range(0, 3) == 0) ? m_sel : int'($urandom_range(0, 7));
            present(sel, off);
            follow("random", 1'b0, 0, 1'b0, z);
        end
    endtask

    initial begin
        test_reset();
        test_connect();
        test_switch();
        test_repeat();
        test_invalid();
        test_off();
        test_back_to_back();
        test_reset_mid();
`ifdef ANAIO_MUX_ABORT_EN
        test_abort();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
